// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, ALUop, mux selects.
// The optional memory wait handshake (MCTRL_MEM_WAIT_EN) is implemented in multicycle_ctrl.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        R_EXEC   = 4'd7,
        R_WB     = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        I_EXEC   = 4'd11,
        I_WB     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // ALUop is also decoded by the ALU control block, so keep these in sync with it.
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_OR    = 3'b010;
    localparam logic [2:0] ALUOP_RTYPE = 3'b100;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic       ext_zero;
        logic       instr_done;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NONE = '0;

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_J) || (op == OP_ADDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle. master = controller side, slave = datapath side.
// Controller outputs keep the datapath's historical MIPS signal names.
interface multicycle_ctrl_if;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegWrite;
    logic       RegDst;
    logic       ALUSrcA;
    logic       ext_zero;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUop;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal;

    // mem_ready is a level: a memory access state completes on the edge where it is 1.
    modport master (
        input  opcode, zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegWrite, RegDst, ALUSrcA, ext_zero, PCSource, ALUSrcB, ALUop,
               state, instr_done, illegal
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegWrite, RegDst, ALUSrcA, ext_zero, PCSource, ALUSrcB, ALUop,
               state, instr_done, illegal
    );

endinterface

// File: rtl/mc_ctrl_outdec.sv
// Combinational state + opcode -> control word decoder for the multi-cycle controller.
// Fed with the next state, so the registered result lines up with that state's cycle.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     st,
    input  logic [5:0] opcode,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = CTRL_NONE;
        case (st)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                // ori zero-extends its immediate; addi keeps the sign-extended add
                if (opcode == OP_ORI) begin
                    ctrl.alu_op   = ALUOP_OR;
                    ctrl.ext_zero = 1'b1;
                end else begin
                    ctrl.alu_op   = ALUOP_ADD;
                end
            end
            I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: state register, registered control word, memory wait.
// Define MCTRL_MEM_WAIT_EN to stall FETCH/MEM_RD/MEM_WR until mem_ready is high.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    state_t     state_q;
    state_t     state_d;
    ctrl_word_t ctrl_d;
    ctrl_word_t ctrl_q;
    logic       ready;
    logic       stall;
    logic       unused_inputs;

`ifdef MCTRL_MEM_WAIT_EN
    assign ready = bus.mem_ready;
`else
    assign ready = 1'b1;
`endif

    // zero goes straight to the datapath PC-enable; the controller never looks at it
    assign unused_inputs = &{1'b0, bus.zero, bus.mem_ready};

    assign stall = ((state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR)) & ~ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = FETCH;
            FETCH:    if (ready) state_d = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:        state_d = R_EXEC;
                    OP_LW, OP_SW:    state_d = MEM_ADDR;
                    OP_BEQ:          state_d = BRANCH;
                    OP_J:            state_d = JUMP;
                    OP_ADDI, OP_ORI: state_d = I_EXEC;
                    default:         state_d = FETCH;
                endcase
            end
            MEM_ADDR: state_d = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (ready) state_d = MEM_WB;
            MEM_WR:   if (ready) state_d = FETCH;
            R_EXEC:   state_d = R_WB;
            I_EXEC:   state_d = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP: state_d = FETCH;
            default:  state_d = IDLE;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .st     (state_d),
        .opcode (bus.opcode),
        .ctrl   (ctrl_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_NONE;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    // Commit strobes are masked while a memory state is still waiting on mem_ready
    assign bus.PCWrite     = ctrl_q.pc_write & ~stall;
    assign bus.IRWrite     = ctrl_q.ir_write & ~stall;
    assign bus.instr_done  = ctrl_q.instr_done & ~stall;
    assign bus.PCWriteCond = ctrl_q.pc_write_cond;
    assign bus.IorD        = ctrl_q.iord;
    assign bus.MemRead     = ctrl_q.mem_read;
    assign bus.MemWrite    = ctrl_q.mem_write;
    assign bus.MemtoReg    = ctrl_q.mem_to_reg;
    assign bus.RegWrite    = ctrl_q.reg_write;
    assign bus.RegDst      = ctrl_q.reg_dst;
    assign bus.ALUSrcA     = ctrl_q.alu_src_a;
    assign bus.ext_zero    = ctrl_q.ext_zero;
    assign bus.PCSource    = ctrl_q.pc_source;
    assign bus.ALUSrcB     = ctrl_q.alu_src_b;
    assign bus.ALUop       = ctrl_q.alu_op;
    assign bus.state       = state_q;

    // The opcode only becomes valid during DECODE, so this flag is decoded from the live IR
    assign bus.illegal = (state_q == DECODE) & ~is_known_op(bus.opcode);

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main control FSM for the MIPS CPU. It sequences one instruction over 3–5 clock cycles and drives the shared datapath: PC, the instruction/data memory port, IR, the register file, and the ALU-source muxes. It emits the 3-bit `ALUop` consumed by the ALU control decoder, so a single ALU serves PC increment, branch target, address generation and execute.

## Interface
Parameters:
- none.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `opcode` in 6: IR[31:26]. Stable from the cycle after `FETCH`.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory handshake. Used only with `MCTRL_MEM_WAIT_EN`.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegWrite`, `RegDst`, `ALUSrcA`, `ext_zero` out 1: datapath controls.
- `PCSource` out 2: 00 ALU, 01 ALUOut, 10 jump target.
- `ALUSrcB` out 2: 00 B, 01 const 4, 10 imm, 11 imm<<2.
- `ALUop` out 3: 000 add, 001 sub, 010 or, 100 R-type/funct.
- `state` out 4: current state, for debug.
- `instr_done` out 1: one-cycle pulse in an instruction's last cycle.
- `illegal` out 1: one-cycle pulse for an unknown opcode.

## Operation
- States (4-bit): IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12.
- Transitions:
  - IDLE→FETCH unconditionally.
  - FETCH→DECODE.
  - DECODE dispatches on `opcode`:
    - R 000000 → R_EXEC.
    - lw 100011, sw 101011 → MEM_ADDR.
    - beq 000100 → BRANCH.
    - j 000010 → JUMP.
    - addi 001000, ori 001101 → I_EXEC.
    - other → FETCH, with `illegal`=1 in DECODE.
  - MEM_ADDR → MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD→MEM_WB.
  - R_EXEC→R_WB.
  - I_EXEC→I_WB.
  - MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP → FETCH.
- Controls asserted per state; unlisted controls are 0:
  - FETCH: MemRead, IRWrite, PCWrite, ALUSrcB=01, ALUop=000.
  - DECODE: ALUSrcB=11, ALUop=000.
  - MEM_ADDR: ALUSrcA, ALUSrcB=10, ALUop=000.
  - MEM_RD: MemRead, IorD.
  - MEM_WB: RegWrite, MemtoReg.
  - MEM_WR: MemWrite, IorD.
  - R_EXEC: ALUSrcA, ALUop=100.
  - R_WB: RegWrite, RegDst.
  - BRANCH: ALUSrcA, ALUop=001, PCWriteCond, PCSource=01.
  - JUMP: PCWrite, PCSource=10.
  - I_EXEC: ALUSrcA, ALUSrcB=10. For ori: ALUop=010 and ext_zero=1. For addi: ALUop=000.
  - I_WB: RegWrite.
- `instr_done`=1 in MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP.
- Datapath PC update = PCWrite | (PCWriteCond & zero). The controller does not combine them.

## Timing
- State register and all control outputs are registered. Outputs are computed from next-state, so they are valid for the whole cycle of the state they belong to, with no glitches.
- Reset: state=IDLE and every output 0 (`PCSource`, `ALUSrcB`, `ALUop` =0). Assertion mid-instruction aborts immediately; no write strobe survives reset.
- Cycles per instruction, FETCH inclusive, no wait: lw 5, sw 4, R 4, addi/ori 4, beq 3, j 3, illegal 2.
- First FETCH is the 2nd rising edge after `rst_n` deasserts.

## Configuration
- `MCTRL_MEM_WAIT_EN` defined:
  - FETCH, MEM_RD and MEM_WR hold until `mem_ready`=1.
  - `MemRead`/`MemWrite` stay asserted throughout the hold.
  - In FETCH, `IRWrite` and `PCWrite` are ANDed combinationally with `mem_ready`.
  - The state advances on the edge where `mem_ready`=1.
- Undefined: `mem_ready` is ignored, and every memory state lasts exactly one cycle.

## Structure
- Package `mc_ctrl_pkg`: state encoding constants, opcode constants, ALUop constants (shared with the ALU control decoder), PCSource/ALUSrcB encodings.
- Sub-module `mc_ctrl_outdec`: purely combinational state+opcode → control-word decoder. The top level holds the state register, the output register and the wait logic.

## Test plan
- Reset mid-MEM_RD: `rst_n`=0 → all outputs 0 asynchronously, state=0. After release: IDLE then FETCH.
- lw (`opcode`=100011): states 1,2,3,4,5. ALUop=000 in 1–3. `RegWrite`&`MemtoReg` only in 5. `instr_done` once.
- beq with `zero`=1, then `zero`=0: both 3 cycles. ALUop=001, PCWriteCond=1, PCSource=01 in BRANCH.
- ori (001101) vs addi (001000): I_EXEC ALUop=010 with ext_zero=1, vs ALUop=000 with ext_zero=0. RegWrite in I_WB, RegDst=0.
- `opcode`=111111: `illegal` pulses in DECODE, returns to FETCH, no RegWrite/MemWrite/PCWrite beyond FETCH.
- With `MCTRL_MEM_WAIT_EN`, `mem_ready` low for 3 cycles in FETCH: MemRead held 4 cycles. IRWrite/PCWrite high only in the ready cycle. DECODE follows.
